// File: rtl/aes_sched_pkg.sv
// Shared types for the SubBytes scheduler: issue tags, FSM states, datapath widths.
package aes_sched_pkg;
  localparam int NCOL    = 4;
  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  typedef struct packed {
    logic       valid;
    logic       is_kw;
    logic [1:0] col;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    KW_ISSUE = 2'd2
  } sched_state_t;
endpackage

// File: rtl/subbytes_tag_pipe.sv
// SB_LAT-deep tag shift register tracking words inside the S-box pipeline.
// Latency SB_LAT cycles (0 = pass-through); no backpressure, synchronous clear.
module subbytes_tag_pipe
  import aes_sched_pkg::*;
#(
  parameter int SB_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  generate
    if (SB_LAT == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign tag_out   = tag_in;
    end else begin : g_pipe
      tag_t stage [SB_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SB_LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= tag_in;
          for (int i = 1; i < SB_LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign tag_out = stage[SB_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/subbytes_sched_32.sv
// Shares one 32-bit SubBytes unit between 128-bit state requests and 32-bit key words.
// State result 5+SB_LAT cycles after accept, key word 2+SB_LAT; readies low while issuing.
module subbytes_sched_32
  import aes_sched_pkg::*;
#(
  parameter int SB_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_req_valid,
  output logic               st_req_ready,
  input  logic [STATE_W-1:0] st_in,
  output logic               st_out_valid,
  output logic [STATE_W-1:0] st_out,
  input  logic               kw_req_valid,
  output logic               kw_req_ready,
  input  logic [WORD_W-1:0]  kw_in,
  output logic               kw_out_valid,
  output logic [WORD_W-1:0]  kw_out,
  output logic [WORD_W-1:0]  sb_x,
  input  logic [WORD_W-1:0]  sb_y
);

  generate
    if (SB_LAT < 0 || SB_LAT > 2) begin : g_bad_lat
      $error("subbytes_sched_32: SB_LAT must be 0..2");
    end
  endgenerate

  sched_state_t       state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic               rr_kw_q;
  logic [STATE_W-1:0] st_buf_q;
  logic [WORD_W-1:0]  kw_buf_q;
  logic [WORD_W-1:0]  asm_q [NCOL-1];
  tag_t               tag_in, tag_tail;
  logic               idle, st_grant, kw_grant;

  assign idle         = (state_q == IDLE);
  assign kw_req_ready = idle & (~st_req_valid | rr_kw_q);
  assign st_req_ready = idle & (~kw_req_valid | ~rr_kw_q);
  assign kw_grant     = kw_req_valid & kw_req_ready;
  assign st_grant     = st_req_valid & st_req_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tag_in  = '0;
    sb_x    = '0;
    case (state_q)
      IDLE: begin
        if (kw_grant) begin
          state_d = KW_ISSUE;
        end else if (st_grant) begin
          state_d = ST_ISSUE;
          col_d   = 2'd0;
        end
      end
      ST_ISSUE: begin
        sb_x   = st_buf_q[(NCOL-1-int'(col_q))*WORD_W +: WORD_W];
        tag_in = '{valid: 1'b1, is_kw: 1'b0, col: col_q};
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) state_d = IDLE;
      end
      KW_ISSUE: begin
        sb_x    = kw_buf_q;
        tag_in  = '{valid: 1'b1, is_kw: 1'b1, col: 2'd0};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  subbytes_tag_pipe #(.SB_LAT(SB_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= 2'd0;
      rr_kw_q      <= 1'b1;
      st_buf_q     <= '0;
      kw_buf_q     <= '0;
      for (int i = 0; i < NCOL-1; i++) asm_q[i] <= '0;
      st_out       <= '0;
      st_out_valid <= 1'b0;
      kw_out       <= '0;
      kw_out_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      st_out_valid <= 1'b0;
      kw_out_valid <= 1'b0;
      if (kw_grant) begin
        kw_buf_q <= kw_in;
        rr_kw_q  <= 1'b0;
      end
      if (st_grant) begin
        st_buf_q <= st_in;
        rr_kw_q  <= 1'b1;
      end
      // Last column bypasses the assemble buffer so st_out only ever loads a complete state.
      if (tag_tail.valid) begin
        if (tag_tail.is_kw) begin
          kw_out       <= sb_y;
          kw_out_valid <= 1'b1;
        end else if (tag_tail.col == 2'd3) begin
          st_out       <= {asm_q[0], asm_q[1], asm_q[2], sb_y};
          st_out_valid <= 1'b1;
        end else begin
          asm_q[tag_tail.col] <= sb_y;
        end
      end
    end
  end

endmodule
